// File: rtl/p_cacheline_adaptor_pkg.sv
// Shared types and sizing for the cacheline adaptor that bridges cache line
// requests onto the 64-bit burst memory bus.
package p_cacheline_adaptor_pkg;

  localparam int unsigned CL_LINE_W   = 256;
  localparam int unsigned CL_BURST_W  = 64;
  localparam int unsigned CL_ADDR_W   = 32;
  localparam int unsigned CL_OFFSET_W = 5;

  // Which upstream cache owns the shared memory port.
  typedef enum logic {
    MUX_ICACHE = 1'b0,
    MUX_DCACHE = 1'b1
  } cache_sel_e;

  // Adaptor control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } adaptor_state_e;

endpackage

// File: rtl/p_burst_counter.sv
// Beat counter for a fixed-length burst.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   en_i          - advance the counter this cycle
//   cnt_o         - current beat index (registered)
//   cnt_nxt_c_o   - beat index after this cycle's update (combinational)
//   wrap_c_o      - high when the last beat is being consumed (combinational)
module p_burst_counter #(
  parameter int unsigned BEATS = 4,
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nxt_c_o,
  output logic             wrap_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Power-of-two beat count, so the increment wraps to zero on its own.
  always_comb begin
    cnt_d    = cnt_q;
    wrap_c_o = 1'b0;
    if (en_i) begin
      cnt_d    = cnt_q + CNT_W'(1);
      wrap_c_o = (cnt_q == CNT_W'(BEATS - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign cnt_nxt_c_o = cnt_d;

endmodule

// File: rtl/p_cacheline_adaptor.sv
// Converts one cacheline read/write from the cache into a BEATS-long burst
// on the memory bus and returns a single-cycle completion pulse.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset (aborts a burst)
//   read_i, write_i     - cache line requests, held until resp_o (write wins)
//   address_i, line_i   - cache-side byte address and write line
//   line_o, resp_o      - assembled read line, one-cycle completion pulse
//   burst_i, resp_i     - memory read beat and beat valid/accept strobe
//   burst_o             - memory write beat
//   address_o           - line-aligned memory address
//   read_o, write_o     - memory read/write request
module p_cacheline_adaptor
  import p_cacheline_adaptor_pkg::*;
#(
  parameter int unsigned LINE_W  = CL_LINE_W,
  parameter int unsigned BURST_W = CL_BURST_W,
  parameter int unsigned ADDR_W  = CL_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int unsigned BEATS  = LINE_W / BURST_W;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LINE_B = LINE_W / 8;

  // Clears the byte-offset bits to give a line-aligned address.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_B - 1);

  adaptor_state_e state_q, state_d;

  logic [ADDR_W-1:0]               address_q, address_d;
  logic [BEATS-1:0][BURST_W-1:0]   rd_line_q, rd_line_d;
  logic [BEATS-1:0][BURST_W-1:0]   wr_line_q, wr_line_d;
  logic [BURST_W-1:0]              burst_q,   burst_d;
  logic                            read_q,    read_d;
  logic                            write_q,   write_d;
  logic                            resp_q,    resp_d;

  logic             cnt_en;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_wrap;

  p_burst_counter #(
    .BEATS (BEATS)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst),
    .en_i        (cnt_en),
    .cnt_o       (cnt),
    .cnt_nxt_c_o (cnt_nxt),
    .wrap_c_o    (cnt_wrap)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    rd_line_d = rd_line_q;
    wr_line_d = wr_line_q;
    cnt_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (write_i) begin
          address_d = address_i & ALIGN_MASK;
          wr_line_d = line_i;
          state_d   = ST_WRITE;
        end else if (read_i) begin
          address_d = address_i & ALIGN_MASK;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        cnt_en = resp_i;
        if (resp_i) begin
          rd_line_d[cnt] = burst_i;
          if (cnt_wrap) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        cnt_en = resp_i;
        if (resp_i && cnt_wrap) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    read_d  = (state_d == ST_READ);
    write_d = (state_d == ST_WRITE);
    resp_d  = (state_d == ST_DONE);
    burst_d = (state_d == ST_WRITE) ? wr_line_d[cnt_nxt] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      address_q <= '0;
      rd_line_q <= '0;
      wr_line_q <= '0;
      burst_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      rd_line_q <= rd_line_d;
      wr_line_q <= wr_line_d;
      burst_q   <= burst_d;
      read_q    <= read_d;
      write_q   <= write_d;
      resp_q    <= resp_d;
    end
  end

  assign line_o    = rd_line_q;
  assign address_o = address_q;
  assign burst_o   = burst_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: doc/p_cacheline_adaptor.md
Name: p_cacheline_adaptor

Overview:
- Sits directly downstream of the pipelined I-cache control, between the cache's physical-memory port and main memory.
- Converts one 256-bit cacheline read or write into a 4-beat burst of 64-bit transfers on the memory bus.
- Returns a single-cycle response to the cache when the whole line has transferred.
- Read path feeds the I-cache's miss fill; the write path exists so the same block serves a write-back D-cache.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, memory beat width in bits.
- ADDR_W, 32, address width.
- BEATS, LINE_W/BURST_W (4), beats per line. Derived; must not be overridden.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- read_i  in  1  cache line read request. Held by the cache until resp_o.
- write_i  in  1  cache line write request. Held by the cache until resp_o.
- address_i  in  ADDR_W  cache-side byte address.
- line_i  in  LINE_W  line to write.
- line_o  out  LINE_W  assembled read line.
- resp_o  out  1  one-cycle completion pulse.
- burst_i  in  BURST_W  memory read beat.
- burst_o  out  BURST_W  memory write beat.
- address_o  out  ADDR_W  line-aligned memory address.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat-valid/accept strobe.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, beat counter=0, line buffer=0, address register=0. All outputs 0, including read_o, write_o and resp_o, which drop immediately even mid-burst. Memory must treat reset as an abort.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On write_i=1: latch address_i and line_i, go to WRITE. Write wins if read_i and write_i are both 1.
  - Else on read_i=1: latch address_i, go to READ.
  - No memory request is driven in IDLE.
- address_o = {latched address[ADDR_W-1:5], 5'b0}, registered, constant for the whole burst.
- READ:
  - read_o=1.
  - Each cycle with resp_i=1: burst_i is stored into line-buffer slice [64*cnt +: 64] and cnt increments. Beat 0 is the low 64 bits.
  - resp_i gaps are legal; the counter holds during them.
  - After beat BEATS-1 is captured, cnt wraps to 0 and the next state is DONE.
- WRITE:
  - write_o=1 and burst_o = line buffer slice cnt.
  - Each resp_i=1 accepts the current beat and advances cnt. burst_o presents the next beat in the following cycle.
  - After beat BEATS-1, cnt wraps to 0 and the next state is DONE.
- DONE:
  - resp_o=1 for exactly one cycle. read_o and write_o are 0. Next state is IDLE.
  - The cache sees resp_o and deasserts its request no later than the following cycle.
  - A request still high in IDLE is treated as a new request.
- line_o is driven from the line buffer. It is valid from the DONE cycle and holds until the next READ captures beat 0.
- resp_i in IDLE or DONE is ignored.
- Dropping read_i or write_i mid-burst has no effect: the burst completes and resp_o still pulses.
- Latency: request seen in IDLE at cycle 0, read_o/write_o high from cycle 1. With back-to-back beats on cycles 1-4, resp_o is high in cycle 5. Minimum turnaround is 5 cycles plus memory latency.
- Beat counter is clog2(BEATS) bits and wraps naturally.

Decomposition:
- The shared package (alongside the cache mux types) holds:
  - an adaptor state enum {IDLE, READ, WRITE, DONE};
  - localparams for line/burst widths and the offset width (5).
- One sub-module, p_burst_counter: a beat counter with enable, wrap flag and async active-low reset. Everything else stays in this module.

Test Plan:
- Read, back-to-back beats: read_i=1, address_i=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles. Required: address_o=0x0000_1220; resp_o pulses once, 5 cycles after the request; line_o={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Read with gaps: same as above, but resp_i is low for 2 cycles between beats 1 and 2. Required: line_o is identical and resp_o is delayed by exactly 2 cycles.
- Write: line_i=0xAAAA..._BBBB..._CCCC..._DDDD..., address_i=0x8000_003F. Required: address_o=0x8000_0020; burst_o sequence is DDDD, CCCC, BBBB, AAAA, one beat per resp_i; write_o drops and resp_o pulses after the 4th beat.
- Simultaneous read_i=write_i=1 in IDLE: required write_o=1, read_o=0, and a write burst occurs.
- Reset mid-read: rst low after 2 beats. Required: read_o drops the same cycle and resp_o is never pulsed. A fresh read after rst high completes normally with cnt starting at 0.
- Spurious resp_i in IDLE: required no state change, line_o unchanged, resp_o stays 0.
